count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Controller that sequences a programmable WIDTH-bit counter through one counting run per start request.
- Latches a terminal value and a direction, counts one step per clk, reports busy/done, and supports abort.
- Sits above the counter datapath: the surrounding logic issues start/stop and consumes count/done.
- Fully synchronous to clk, except reset.

Parameters:
- WIDTH, 4, counter and terminal-value width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- stop  input  1  abort request; sampled only in RUN.
- dir  input  1  0 = count up, 1 = count down; latched at accepted start.
- term  input  WIDTH  terminal value; latched at accepted start.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on stop-terminated run.

Behaviour:
- Reset (async, active-high): state=IDLE, count=0, busy=0, done=0, aborted=0, latched term/dir=0.
- States: IDLE, RUN, DONE. All outputs are registered; no combinational paths from inputs to outputs.
- IDLE:
  - start=1: latch term→T and dir→D; load count=0 (D=0) or count=T (D=1); go RUN.
  - start=0: hold count.
  - stop is ignored.
- RUN (busy=1):
  - stop=1 has priority: go IDLE, hold count, pulse aborted next cycle. No done.
  - Else, if D=0 and count==T, or D=1 and count==0: go DONE, hold count.
  - Else count±1.
  - A run therefore occupies exactly T+1 RUN cycles in either direction.
  - start is ignored in RUN; term/dir changes mid-run have no effect.
- DONE: done=1 for exactly this one cycle, busy=0, count holds its final value.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back runs, no idle gap).
  - Otherwise go IDLE.
- Boundaries:
  - T=0: one RUN cycle, then DONE; count stays 0.
  - T=2^WIDTH-1 up: counts to all-ones, no wrap, no overflow.
  - Counter never wraps in any mode.
- Simultaneous events:
  - start+stop in IDLE: start accepted.
  - start+stop in RUN: stop wins, start dropped.
- Output exclusivity: done and aborted are never both 1; busy is 0 whenever done or aborted is 1.
- Reset asserted mid-run: immediate return to reset values, no done/aborted pulse.

Optional Feature:
- Macro: COUNT_SEQUENCER_AUTO_RELOAD_EN.
- Defined:
  - On reaching terminal in RUN, go DONE (done pulses) and reload count from the latched start value: 0 if up, T if down. Then re-enter RUN the next cycle with the same T/D, without a new start.
  - Repeats until stop, which returns to IDLE with an aborted pulse and holds count.
  - start in DONE is ignored in this mode.
- Undefined: single-shot behaviour as above.

Test Plan:
- Reset then idle, no start for 5 cycles → count=0, busy=0, done=0, aborted=0 throughout.
- Up run, T=3, D=0, start 1 cycle → count 0,1,2,3 with busy=1 (4 cycles), then done=1 with count=3, then IDLE, count held at 3.
- Down run, T=2, D=1 → count 2,1,0, then done; T=0 up → one busy cycle, done, count=0.
- Abort: T=10 up, assert stop when count=4 → next state IDLE, count=4, aborted=1 for one cycle, done never asserted; start+stop together in RUN → stop wins.
- Back-to-back: start held high through DONE, T=1 → runs 0,1,done,0,1,done with no IDLE cycle between runs; reset asserted at count=1 of the second run → immediate count=0, busy=0, no pulse.
- AUTO_RELOAD build, T=1 up → 0,1,done,0,1,done repeating until stop → aborted pulse, IDLE.

Source files
------------

// File: rtl/count_sequencer.sv
// count_sequencer
//   Sequences a WIDTH-bit counter through one counting run per accepted start.
//   The terminal value and the direction are latched when a start is accepted.
//   The counter then moves one step per clock until it reaches its end value,
//   or until stop aborts the run.
//
//   Optional build macro: COUNT_SEQUENCER_AUTO_RELOAD_EN
//     When this macro is defined, reaching the terminal value pulses done and
//     reloads the start value. The next cycle starts a new run with the same
//     terminal and direction. Only stop ends the repetition, and a start seen
//     in DONE is ignored.
//
// Parameters
//   WIDTH   counter / terminal width in bits (2..16)
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    run request, sampled in IDLE and DONE
//   stop     abort request, sampled in RUN (takes priority over start)
//   dir      0 = count up, 1 = count down, latched at accepted start
//   term     terminal value, latched at accepted start
//   count    registered counter value
//   busy     high while running
//   done     one-cycle pulse on normal completion
//   aborted  one-cycle pulse after a stop-terminated run
module count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] term_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             aborted_nxt;
  logic             at_term;

  // Only called when the end value has not been reached yet, so the
  // counter never wraps.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic             down);
    if (down)
      return c - 1'b1;
    else
      return c + 1'b1;
  endfunction

  // A run always starts at 0 when counting up, or at T when counting down.
  function automatic logic [WIDTH-1:0] start_value(input logic [WIDTH-1:0] t,
                                                   input logic             down);
    if (down)
      return t;
    else
      return '0;
  endfunction

  // An up run ends at T. A down run ends at 0.
  assign at_term = dir_q ? (count == '0) : (count == term_q);

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    term_nxt    = term_q;
    dir_nxt     = dir_q;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          term_nxt  = term;
          dir_nxt   = dir;
          count_nxt = start_value(term, dir);
          state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_nxt   = S_IDLE;
          aborted_nxt = 1'b1;
        end else if (at_term) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
          count_nxt = start_value(term_q, dir_q);
`endif
        end else begin
          count_nxt = step_count(count, dir_q);
        end
      end

      S_DONE: begin
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
        // The count was already reloaded on entry, so simply resume running.
        state_nxt = S_RUN;
`else
        if (start) begin
          term_nxt  = term;
          dir_nxt   = dir;
          count_nxt = start_value(term, dir);
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
`endif
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_RUN);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Registered outputs and latched run parameters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      term_q  <= '0;
      dir_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      count   <= count_nxt;
      term_q  <= term_nxt;
      dir_q   <= dir_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic             dir;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             aborted;

  int checks = 0;
  int errors = 0;

  count_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .term    (term),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input int c, input int b, input int d, input int a);
    chk({tag, ".count"},   32'(count),   c);
    chk({tag, ".busy"},    32'(busy),    b);
    chk({tag, ".done"},    32'(done),    d);
    chk({tag, ".aborted"}, 32'(aborted), a);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [WIDTH-1:0] t, input logic d);
    term  = t;
    dir   = d;
    start = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b0;
    term  = '0;
    #1;
    expect_out("reset", 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("idle", 0, 0, 0, 0);
    end

`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
    // Auto reload with T=1 counting up
    go(4'd1, 1'b0);
    step(); expect_out("ar.r0", 0, 1, 0, 0);
    start = 1'b0;
    step(); expect_out("ar.r1", 1, 1, 0, 0);
    step(); expect_out("ar.d1", 0, 0, 1, 0);
    start = 1'b1;  // must be ignored in DONE
    step(); expect_out("ar.r0b", 0, 1, 0, 0);
    start = 1'b0;
    step(); expect_out("ar.r1b", 1, 1, 0, 0);
    step(); expect_out("ar.d2", 0, 0, 1, 0);
    step(); expect_out("ar.r0c", 0, 1, 0, 0);
    stop = 1'b1;
    step(); expect_out("ar.abort", 0, 0, 0, 1);
    stop = 1'b0;
    step(); expect_out("ar.idle", 0, 0, 0, 0);
    step(); expect_out("ar.idle2", 0, 0, 0, 0);
`else
    // Up run with T=3
    go(4'd3, 1'b0);
    step(); expect_out("up.c0", 0, 1, 0, 0);
    start = 1'b0;
    term  = 4'd9;  // a mid-run change must have no effect
    dir   = 1'b1;
    step(); expect_out("up.c1", 1, 1, 0, 0);
    step(); expect_out("up.c2", 2, 1, 0, 0);
    step(); expect_out("up.c3", 3, 1, 0, 0);
    step(); expect_out("up.done", 3, 0, 1, 0);
    step(); expect_out("up.idle", 3, 0, 0, 0);
    stop = 1'b1;  // stop is ignored in IDLE
    step(); expect_out("up.idle2", 3, 0, 0, 0);
    stop = 1'b0;

    // Down run with T=2
    go(4'd2, 1'b1);
    step(); expect_out("dn.c2", 2, 1, 0, 0);
    start = 1'b0;
    dir   = 1'b0;
    step(); expect_out("dn.c1", 1, 1, 0, 0);
    step(); expect_out("dn.c0", 0, 1, 0, 0);
    step(); expect_out("dn.done", 0, 0, 1, 0);
    step(); expect_out("dn.idle", 0, 0, 0, 0);

    // T=0 counting up
    go(4'd0, 1'b0);
    step(); expect_out("t0.run", 0, 1, 0, 0);
    start = 1'b0;
    step(); expect_out("t0.done", 0, 0, 1, 0);
    step(); expect_out("t0.idle", 0, 0, 0, 0);

    // Abort: T=10 counting up, stop asserted when count reaches 4
    go(4'd10, 1'b0);
    step(); expect_out("ab.c0", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out("ab.run", i, 1, 0, 0);
    end
    stop = 1'b1;
    step(); expect_out("ab.pulse", 4, 0, 0, 1);
    stop = 1'b0;
    step(); expect_out("ab.idle", 4, 0, 0, 0);

    // start and stop together: start wins in IDLE, stop wins in RUN
    go(4'd5, 1'b0);
    stop = 1'b1;
    step(); expect_out("ss.idle", 0, 1, 0, 0);
    step(); expect_out("ss.run", 0, 0, 0, 1);
    start = 1'b0;
    stop  = 1'b0;
    step(); expect_out("ss.after", 0, 0, 0, 0);

    // Full-scale up run with no wrap
    go(4'd15, 1'b0);
    step(); expect_out("max.c0", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      expect_out("max.run", i, 1, 0, 0);
    end
    step(); expect_out("max.done", 15, 0, 1, 0);
    step(); expect_out("max.idle", 15, 0, 0, 0);

    // Back-to-back runs with start held, then reset asserted mid-run
    go(4'd1, 1'b0);
    step(); expect_out("bb.a0", 0, 1, 0, 0);
    step(); expect_out("bb.a1", 1, 1, 0, 0);
    step(); expect_out("bb.adone", 1, 0, 1, 0);
    step(); expect_out("bb.b0", 0, 1, 0, 0);
    step(); expect_out("bb.b1", 1, 1, 0, 0);
    reset = 1'b1;
    #1;
    expect_out("bb.rst", 0, 0, 0, 0);
    start = 1'b0;
    step(); expect_out("bb.rsthold", 0, 0, 0, 0);
    reset = 1'b0;
    step(); expect_out("bb.idle", 0, 0, 0, 0);
    step(); expect_out("bb.idle2", 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
